// File: rtl/pipe_pulse_pkg.sv
// Shared types and constants for the pipe-pulse collector and its event FIFO.
package pipe_pulse_pkg;

   localparam int PIPE_PULSE_TS_W       = 16;
   localparam int PIPE_PULSE_LEN_W      = 8;
   localparam int PIPE_PULSE_DROP_CNT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pp_state_t;

   typedef struct packed {
      logic [PIPE_PULSE_TS_W-1:0]  ts;
      logic [PIPE_PULSE_LEN_W-1:0] len;
   } pp_event_t;

endpackage

// File: rtl/pipe_pulse_fifo.sv
// Small synchronous event FIFO; head output holds the last popped entry once empty.
module pipe_pulse_fifo
   import pipe_pulse_pkg::*;
#(
   parameter int W     = PIPE_PULSE_TS_W + PIPE_PULSE_LEN_W,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [W-1:0]  last_pop;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;

   assign wr_idx = wr_ptr[AW-1:0];
   assign rd_idx = rd_ptr[AW-1:0];
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
   assign dout   = empty ? last_pop : mem[rd_idx];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         last_pop <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            last_pop <= mem[rd_idx];
         end
      end
   end

   // Storage carries no reset; a push into a full FIFO only happens alongside a pop.
   always_ff @(posedge clk) begin
      if (push) mem[wr_idx] <= din;
   end

endmodule

// File: rtl/pipe_pulse_collector.sv
// Records each high run of pipe_in as {start ts, length} and queues it for the host.
// Optional PIPE_PULSE_COLLECTOR_DROP_CNT_EN adds the saturating drop_cnt output.
module pipe_pulse_collector
   import pipe_pulse_pkg::*;
#(
   parameter int TS_W  = PIPE_PULSE_TS_W,
   parameter int LEN_W = PIPE_PULSE_LEN_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pipe_in,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [TS_W-1:0]  ev_ts,
   output logic [LEN_W-1:0] ev_len,
   output logic             ev_ovf,
   output logic             busy
`ifdef PIPE_PULSE_COLLECTOR_DROP_CNT_EN
   ,
   output logic [PIPE_PULSE_DROP_CNT_W-1:0] drop_cnt
`endif
);

   localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

   pp_state_t        state;
   pp_state_t        state_nxt;
   logic [TS_W-1:0]  ts;
   logic [TS_W-1:0]  start_ts;
   logic [LEN_W-1:0] len;
   logic             ev_push;
   logic             ev_pop;
   logic             accept;
   logic             fifo_full;
   logic             fifo_empty;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         ts    <= '0;
      end else begin
         state <= state_nxt;
         ts    <= ts + TS_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      ev_push   = 1'b0;
      case (state)
         IDLE: if (pipe_in) state_nxt = RUN;
         RUN: begin
            if (!pipe_in) begin
               ev_push   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Run capture: the first high sample opens the run at length 1.
   always_ff @(posedge clk) begin
      if (state == IDLE && pipe_in) begin
         start_ts <= ts;
         len      <= LEN_W'(1);
      end else if (state == RUN && pipe_in && len != LEN_MAX) begin
         len <= len + LEN_W'(1);
      end
   end

   assign busy     = (state == RUN);
   assign ev_valid = !fifo_empty;
   assign ev_pop   = ev_valid && ev_ready;
   assign accept   = ev_push && (!fifo_full || ev_pop);

   always_ff @(posedge clk) begin
      if (!reset_n) ev_ovf <= 1'b0;
      else if (ev_push && !accept) ev_ovf <= 1'b1;
   end

`ifdef PIPE_PULSE_COLLECTOR_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) drop_cnt <= '0;
      else if (ev_push && !accept && drop_cnt != {PIPE_PULSE_DROP_CNT_W{1'b1}})
         drop_cnt <= drop_cnt + PIPE_PULSE_DROP_CNT_W'(1);
   end
`endif

   pipe_pulse_fifo #(
      .W     (TS_W + LEN_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (accept),
      .din     ({start_ts, len}),
      .pop     (ev_pop),
      .dout    ({ev_ts, ev_len}),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_pipe_pulse_collector.sv
// Scenario bench for pipe_pulse_collector; events are checked against a queue on every handshake.
module tb_pipe_pulse_collector;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        pipe_in = 1'b0;
   logic        ev_ready = 1'b0;
   logic        ev_valid;
   logic [15:0] ev_ts;
   logic [7:0]  ev_len;
   logic        ev_ovf;
   logic        busy;

   logic        pipe_in_w = 1'b0;
   logic        ev_ready_w = 1'b1;
   logic        w_valid;
   logic [3:0]  w_ts;
   logic [7:0]  w_len;
   logic        w_ovf;
   logic        w_busy;

`ifdef PIPE_PULSE_COLLECTOR_DROP_CNT_EN
   logic [7:0]  drop_cnt;
   logic [7:0]  w_drop_cnt;
`endif

   typedef struct {
      logic [15:0] ts;
      logic [7:0]  len;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   pipe_pulse_collector dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .pipe_in  (pipe_in),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_ts    (ev_ts),
      .ev_len   (ev_len),
      .ev_ovf   (ev_ovf),
      .busy     (busy)
`ifdef PIPE_PULSE_COLLECTOR_DROP_CNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   pipe_pulse_collector #(.TS_W(4)) dut_w (
      .clk      (clk),
      .reset_n  (reset_n),
      .pipe_in  (pipe_in_w),
      .ev_valid (w_valid),
      .ev_ready (ev_ready_w),
      .ev_ts    (w_ts),
      .ev_len   (w_len),
      .ev_ovf   (w_ovf),
      .busy     (w_busy)
`ifdef PIPE_PULSE_COLLECTOR_DROP_CNT_EN
      ,
      .drop_cnt (w_drop_cnt)
`endif
   );

   // Every accepted handshake must match the oldest expected event.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got ts=%0d len=%0d, required no event", ev_ts, ev_len);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (ev_ts !== e.ts || ev_len !== e.len) begin
               errors++;
               $display("FAIL sb_event: got ts=%0d len=%0d, required ts=%0d len=%0d",
                        ev_ts, ev_len, e.ts, e.len);
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int k);
      while (cyc < k) step();
   endtask

   task automatic do_reset;
      reset_n   = 1'b0;
      pipe_in   = 1'b0;
      pipe_in_w = 1'b0;
      step();
      reset_n = 1'b1;
      cyc     = 0;
      q.delete();
   endtask

   task automatic push_exp(input logic [15:0] ts, input logic [7:0] len);
      exp_t e;
      e.ts  = ts;
      e.len = len;
      q.push_back(e);
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if ({ev_valid, ev_ts, ev_len, ev_ovf, busy} !== 27'd0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b ts=%0d len=%0d ovf=%b busy=%b, required all 0",
                  ev_valid, ev_ts, ev_len, ev_ovf, busy);
      end
`ifdef PIPE_PULSE_COLLECTOR_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt);
      end
`endif
   endtask

   task automatic test_basic;
      do_reset();
      ev_ready = 1'b1;
      goto(3);
      pipe_in = 1'b1;
      push_exp(16'd3, 8'd3);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_c3: got %b, required 0", busy);
      end
      step();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_c4: got %b, required 1", busy);
      end
      goto(6);
      pipe_in = 1'b0;
      checks++;
      if (busy !== 1'b1 || ev_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_c6: got busy=%b valid=%b, required busy=1 valid=0", busy, ev_valid);
      end
      step();
      checks++;
      if (busy !== 1'b0 || ev_valid !== 1'b1 || ev_ts !== 16'd3 || ev_len !== 8'd3) begin
         errors++;
         $display("FAIL basic_c7: got busy=%b valid=%b ts=%0d len=%0d, required 0 1 3 3",
                  busy, ev_valid, ev_ts, ev_len);
      end
      step();
      checks++;
      if (ev_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_c8_valid: got %b, required 0", ev_valid);
      end
   endtask

   task automatic test_saturation;
      do_reset();
      ev_ready = 1'b1;
      goto(2);
      pipe_in = 1'b1;
      push_exp(16'd2, 8'd255);
      repeat (300) step();
      pipe_in = 1'b0;
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_len !== 8'd255) begin
         errors++;
         $display("FAIL sat_len: got valid=%b len=%0d, required valid=1 len=255", ev_valid, ev_len);
      end
      repeat (4) step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL sat_pending: got %0d events outstanding, required 0", q.size());
      end
   endtask

   task automatic test_overflow;
      do_reset();
      ev_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         goto(10 + 3 * k);
         pipe_in = 1'b1;
         if (k < 4) push_exp(16'(10 + 3 * k), 8'd1);
         step();
         pipe_in = 1'b0;
      end
      checks++;
      if (ev_ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_before_drop: got %b, required 0", ev_ovf);
      end
      step();
      checks++;
      if (ev_ovf !== 1'b1 || ev_valid !== 1'b1 || ev_ts !== 16'd10) begin
         errors++;
         $display("FAIL ovf_after_drop: got ovf=%b valid=%b ts=%0d, required 1 1 10",
                  ev_ovf, ev_valid, ev_ts);
      end
`ifdef PIPE_PULSE_COLLECTOR_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 8'd1) begin
         errors++;
         $display("FAIL ovf_drop_cnt: got %0d, required 1", drop_cnt);
      end
`endif
      ev_ready = 1'b1;
      repeat (6) step();
      checks++;
      if (q.size() != 0 || ev_valid !== 1'b0 || ev_ts !== 16'd19 || ev_len !== 8'd1) begin
         errors++;
         $display("FAIL ovf_drain: got pending=%0d valid=%b ts=%0d len=%0d, required 0 0 19 1",
                  q.size(), ev_valid, ev_ts, ev_len);
      end
   endtask

   task automatic test_reset_mid_run;
      ev_ready = 1'b1;
      pipe_in  = 1'b1;
      repeat (3) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      pipe_in = 1'b0;
      cyc     = 0;
      checks++;
      if (busy !== 1'b0 || ev_valid !== 1'b0 || ev_ovf !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset: got busy=%b valid=%b ovf=%b, required all 0",
                  busy, ev_valid, ev_ovf);
      end
`ifdef PIPE_PULSE_COLLECTOR_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL midrun_drop_cnt: got %0d, required 0", drop_cnt);
      end
`endif
      goto(3);
      checks++;
      if (ev_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrun_no_event: got valid=%b, required 0", ev_valid);
      end
      pipe_in = 1'b1;
      push_exp(16'd3, 8'd1);
      step();
      pipe_in = 1'b0;
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_ts !== 16'd3) begin
         errors++;
         $display("FAIL midrun_ts_restart: got valid=%b ts=%0d, required 1 3", ev_valid, ev_ts);
      end
      step();
   endtask

   task automatic test_full_concurrent;
      int n;
      do_reset();
      ev_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         goto(2 + 3 * k);
         pipe_in = 1'b1;
         push_exp(16'(2 + 3 * k), 8'd1);
         step();
         pipe_in = 1'b0;
      end
      goto(14);
      pipe_in = 1'b1;
      push_exp(16'd14, 8'd2);
      step();
      step();
      pipe_in  = 1'b0;
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      checks++;
      if (ev_ovf !== 1'b0 || ev_valid !== 1'b1 || ev_ts !== 16'd5) begin
         errors++;
         $display("FAIL full_pop_accept: got ovf=%b valid=%b ts=%0d, required 0 1 5",
                  ev_ovf, ev_valid, ev_ts);
      end
      ev_ready = 1'b1;
      n = 0;
      repeat (8) begin
         if (ev_valid === 1'b1) n++;
         step();
      end
      checks++;
      if (n != 4 || q.size() != 0) begin
         errors++;
         $display("FAIL full_occupancy: got %0d back-to-back pops, %0d pending, required 4 and 0",
                  n, q.size());
      end
   endtask

   task automatic test_wrap;
      do_reset();
      goto(17);
      pipe_in_w = 1'b1;
      step();
      pipe_in_w = 1'b0;
      checks++;
      if (w_busy !== 1'b1) begin
         errors++;
         $display("FAIL wrap_busy: got %b, required 1", w_busy);
      end
      step();
      checks++;
      if (w_valid !== 1'b1 || w_ts !== 4'd1 || w_len !== 8'd1) begin
         errors++;
         $display("FAIL wrap_ts: got valid=%b ts=%0d len=%0d, required 1 1 1", w_valid, w_ts, w_len);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_overflow();
      test_reset_mid_run();
      test_full_concurrent();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
